// File: rtl/procyon_system_pkg.sv
// Shared system-bus definitions: line-master state encoding and default line size.
package procyon_system_pkg;

  localparam int unsigned DEFAULT_LINE_SIZE = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } line_state_e;

endpackage

// File: rtl/wb_line_master.sv
// Wishbone B4 pipelined master: expands one cache-line request into a word burst
// and reassembles the returned line, holding CYC for the whole transfer.
module wb_line_master
  import procyon_system_pkg::*;
#(
  parameter int unsigned OPTN_WB_DATA_WIDTH = 16,
  parameter int unsigned OPTN_WB_ADDR_WIDTH = 32,
  parameter int unsigned OPTN_LINE_SIZE     = DEFAULT_LINE_SIZE
) (
  input  logic                            i_wb_clk,
  input  logic                            i_wb_rst,
  input  logic                            i_req_valid,
  output logic                            o_req_ready,
  input  logic                            i_req_we,
  input  logic [OPTN_WB_ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [OPTN_LINE_SIZE*8-1:0]     i_req_data,
  output logic                            o_rsp_valid,
  output logic [OPTN_LINE_SIZE*8-1:0]     o_rsp_data,
  output logic                            o_wb_cyc,
  output logic                            o_wb_stb,
  output logic                            o_wb_we,
  output logic [OPTN_WB_DATA_WIDTH/8-1:0] o_wb_sel,
  output logic [OPTN_WB_ADDR_WIDTH-1:0]   o_wb_addr,
  output logic [OPTN_WB_DATA_WIDTH-1:0]   o_wb_data,
  input  logic [OPTN_WB_DATA_WIDTH-1:0]   i_wb_data,
  input  logic                            i_wb_ack,
  input  logic                            i_wb_stall
);

  localparam int unsigned DW           = OPTN_WB_DATA_WIDTH;
  localparam int unsigned AW           = OPTN_WB_ADDR_WIDTH;
  localparam int unsigned WB_WORD_SIZE = OPTN_WB_DATA_WIDTH / 8;
  localparam int unsigned LINE_WORDS   = OPTN_LINE_SIZE / WB_WORD_SIZE;
  localparam int unsigned LINE_BITS    = OPTN_LINE_SIZE * 8;
  localparam int unsigned CNT_W        = $clog2(LINE_WORDS) + 1;

  localparam logic [AW-1:0]    LINE_MASK = ~AW'(OPTN_LINE_SIZE - 1);
  localparam logic [AW-1:0]    WORD_STEP = AW'(WB_WORD_SIZE);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(LINE_WORDS);

  line_state_e state_q, state_d;

  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 we_q, we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [LINE_BITS-1:0] wline_q, wline_d;
  logic [LINE_BITS-1:0] rline_q, rline_d;
  logic [CNT_W-1:0]     issue_q, issue_d;
  logic [CNT_W-1:0]     ack_q, ack_d;
  logic                 rsp_valid_q, rsp_valid_d;

  logic             req_fire;
  logic             wb_take;
  logic             ack_take;
  logic             line_done;
  logic [CNT_W-1:0] issue_nxt;
  logic [CNT_W-1:0] ack_nxt;

  assign req_fire  = (state_q == ST_IDLE) & i_req_valid;
  assign wb_take   = (state_q == ST_BUSY) & stb_q & ~i_wb_stall;
  // Acks outside CYC or beyond the last word are stray and dropped.
  assign ack_take  = (state_q == ST_BUSY) & cyc_q & i_wb_ack & (ack_q != CNT_FULL);
  assign issue_nxt = issue_q + CNT_W'(1);
  assign ack_nxt   = ack_q + CNT_W'(1);
  assign line_done = ack_take & (ack_nxt == CNT_FULL);

  // State register
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_fire)  state_d = ST_BUSY;
      ST_BUSY: if (line_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wline_d     = wline_q;
    rline_d     = rline_q;
    issue_d     = issue_q;
    ack_d       = ack_q;
    rsp_valid_d = (state_d == ST_DONE);

    unique case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = i_req_we;
          addr_d  = i_req_addr & LINE_MASK;
          wline_d = i_req_data;
          wdata_d = i_req_data[DW-1:0];
          issue_d = '0;
          ack_d   = '0;
        end
      end
      ST_BUSY: begin
        if (wb_take) begin
          issue_d = issue_nxt;
          addr_d  = addr_q + WORD_STEP;
          stb_d   = (issue_nxt != CNT_FULL);
          for (int unsigned k = 0; k < LINE_WORDS; k++) begin
            if (issue_nxt == CNT_W'(k)) wdata_d = wline_q[k*DW +: DW];
          end
        end
        if (ack_take) begin
          ack_d = ack_nxt;
          if (!we_q) begin
            for (int unsigned k = 0; k < LINE_WORDS; k++) begin
              if (ack_q == CNT_W'(k)) rline_d[k*DW +: DW] = i_wb_data;
            end
          end
        end
        if (line_done) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
        end
      end
      ST_DONE: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
      end
      default: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wline_q     <= '0;
      rline_q     <= '0;
      issue_q     <= '0;
      ack_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wline_q     <= wline_d;
      rline_q     <= rline_d;
      issue_q     <= issue_d;
      ack_q       <= ack_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rline_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_sel    = '1;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = wdata_q;

endmodule

// File: tb/tb_wb_line_master.sv
// Directed bench for wb_line_master: a cycle-stepped pipelined slave plus
// per-scenario tasks with inline expected-value checks.
module tb_wb_line_master;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [31:0]  req_addr;
  logic [255:0] req_data;
  logic         rsp_valid;
  logic [255:0] rsp_data;
  logic         wb_cyc, wb_stb, wb_we;
  logic [1:0]   wb_sel;
  logic [31:0]  wb_addr;
  logic [15:0]  wb_wdata;
  logic [15:0]  wb_rdata;
  logic         wb_ack, wb_stall;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] acc_addr[$];
  logic [15:0] acc_data[$];
  logic        acc_we[$];
  logic [31:0] stb_addr_h[$];
  logic [15:0] stb_data_h[$];
  logic        cyc_hist[0:127];
  int          rsp_cycle, last_stb, last_ack, ready_seen;

  wb_line_master dut (
    .i_wb_clk    (clk),
    .i_wb_rst    (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_wb_cyc    (wb_cyc),
    .o_wb_stb    (wb_stb),
    .o_wb_we     (wb_we),
    .o_wb_sel    (wb_sel),
    .o_wb_addr   (wb_addr),
    .o_wb_data   (wb_wdata),
    .i_wb_data   (wb_rdata),
    .i_wb_ack    (wb_ack),
    .i_wb_stall  (wb_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input logic we, input logic [31:0] addr, input logic [255:0] data);
    req_we    = we;
    req_addr  = addr;
    req_data  = data;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Slave model: cycle 1 is the first cycle after the accept edge. Each accepted
  // word is acked no earlier than the next cycle, with at least ack_gap cycles between acks.
  task automatic run_slave(input int stall_word, input int stall_len, input int ack_gap,
                           input int stop_acks, input bit spurious, input int budget);
    int          pend_rdy[$];
    logic [31:0] pend_addr[$];
    int          acks = 0;
    int          stall_left = stall_len;
    int          last = -100;
    bit          spur_done = 1'b0;
    bit          stall;
    acc_addr.delete(); acc_data.delete(); acc_we.delete();
    stb_addr_h.delete(); stb_data_h.delete();
    rsp_cycle = -1; last_stb = -1; last_ack = -1; ready_seen = 0;
    for (int i = 0; i < 128; i++) cyc_hist[i] = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (stop_acks > 0 && acks == stop_acks) begin
        wb_ack = 1'b0; wb_stall = 1'b0;
        break;
      end
      cyc_hist[c] = wb_cyc;
      if (req_ready) ready_seen++;
      stall = 1'b0;
      if (wb_stb) begin
        stb_addr_h.push_back(wb_addr);
        stb_data_h.push_back(wb_wdata);
        last_stb = c;
        if (acc_addr.size() == stall_word && stall_left > 0) begin
          stall = 1'b1;
          stall_left--;
        end
        if (!stall) begin
          acc_addr.push_back(wb_addr);
          acc_data.push_back(wb_wdata);
          acc_we.push_back(wb_we);
          pend_rdy.push_back(c + 1);
          pend_addr.push_back(wb_addr);
        end
      end
      wb_stall = stall;
      wb_ack   = 1'b0;
      wb_rdata = 16'h0;
      if (pend_rdy.size() > 0 && pend_rdy[0] <= c && c >= last + ack_gap) begin
        wb_ack   = 1'b1;
        wb_rdata = pend_addr[0][15:0];
        void'(pend_rdy.pop_front());
        void'(pend_addr.pop_front());
        last     = c;
        last_ack = c;
        acks++;
      end else if (spurious && !spur_done && acks == 16 && c == last + 1) begin
        wb_ack    = 1'b1;
        wb_rdata  = 16'hDEAD;
        spur_done = 1'b1;
      end
      if (rsp_valid) begin
        rsp_cycle = c;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
    wb_ack = 1'b0; wb_stall = 1'b0; wb_rdata = '0;
    tick(); tick(); tick();
    n_checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_we !== 1'b0)
      $display("FAIL rst_ctl got cyc=%b stb=%b we=%b exp 000", wb_cyc, wb_stb, wb_we); else n_pass++;
    n_checks++; if (wb_addr !== 32'h0 || wb_wdata !== 16'h0)
      $display("FAIL rst_bus got addr=%h data=%h exp 0", wb_addr, wb_wdata); else n_pass++;
    n_checks++; if (wb_sel !== 2'b11) $display("FAIL rst_sel got %b exp 11", wb_sel); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0 || rsp_data !== 256'h0)
      $display("FAIL rst_rsp got v=%b d=%h exp 0", rsp_valid, rsp_data); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready); else n_pass++;
  endtask

  task automatic test_read_basic();
    logic [255:0] exp;
    for (int k = 0; k < 16; k++) exp[k*16 +: 16] = 16'(32'h40 + 2*k);
    issue_req(1'b0, 32'h0000_0046, '0);
    run_slave(-1, 0, 1, 0, 1'b0, 64);
    n_checks++; if (rsp_cycle !== 18) $display("FAIL rd_rsp_cycle got %0d exp 18", rsp_cycle); else n_pass++;
    n_checks++; if (last_stb !== 16) $display("FAIL rd_last_stb got %0d exp 16", last_stb); else n_pass++;
    n_checks++; if (last_ack !== 17) $display("FAIL rd_last_ack got %0d exp 17", last_ack); else n_pass++;
    n_checks++; if (ready_seen !== 0) $display("FAIL rd_ready_busy got %0d exp 0", ready_seen); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      n_checks++; if (acc_addr[k] !== 32'h40 + 32'(2*k) || acc_we[k] !== 1'b0)
        $display("FAIL rd_addr[%0d] got %h we=%b exp %h we=0", k, acc_addr[k], acc_we[k], 32'h40 + 32'(2*k));
      else n_pass++;
    end
    n_checks++; if (rsp_data !== exp) $display("FAIL rd_line got %h exp %h", rsp_data, exp); else n_pass++;
    tick(); wb_ack = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL rd_after got v=%b rdy=%b exp 0 1", rsp_valid, req_ready); else n_pass++;
    n_checks++; if (rsp_data !== exp) $display("FAIL rd_hold got %h exp %h", rsp_data, exp); else n_pass++;
  endtask

  task automatic test_write();
    logic [255:0] wl;
    logic [255:0] prev;
    prev = rsp_data;
    for (int k = 0; k < 16; k++) wl[k*16 +: 16] = 16'hA000 + 16'(k);
    issue_req(1'b1, 32'h0000_0100, wl);
    n_checks++; if (wb_sel !== 2'b11 || wb_we !== 1'b1)
      $display("FAIL wr_sel_we got sel=%b we=%b exp 11 1", wb_sel, wb_we); else n_pass++;
    run_slave(-1, 0, 1, 0, 1'b0, 64);
    n_checks++; if (acc_addr.size() !== 16) $display("FAIL wr_count got %0d exp 16", acc_addr.size()); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      n_checks++; if (acc_addr[k] !== 32'h100 + 32'(2*k) || acc_data[k] !== 16'hA000 + 16'(k) || acc_we[k] !== 1'b1)
        $display("FAIL wr_word[%0d] got a=%h d=%h we=%b exp a=%h d=%h we=1", k, acc_addr[k], acc_data[k],
                 acc_we[k], 32'h100 + 32'(2*k), 16'hA000 + 16'(k));
      else n_pass++;
    end
    n_checks++; if (rsp_cycle !== 18) $display("FAIL wr_rsp_cycle got %0d exp 18", rsp_cycle); else n_pass++;
    n_checks++; if (rsp_data !== prev) $display("FAIL wr_rsp_data got %h exp %h", rsp_data, prev); else n_pass++;
    tick(); wb_ack = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL wr_pulse got %b exp 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_stall();
    logic [255:0] wl;
    int hold_cnt = 0;
    int bad_hold = 0;
    for (int k = 0; k < 16; k++) wl[k*16 +: 16] = 16'hA000 + 16'(k);
    issue_req(1'b1, 32'h0000_0100, wl);
    run_slave(3, 4, 1, 0, 1'b0, 64);
    foreach (stb_addr_h[i]) if (stb_addr_h[i] == 32'h106) begin
      hold_cnt++;
      if (stb_data_h[i] !== 16'hA003) bad_hold++;
    end
    n_checks++; if (hold_cnt !== 5) $display("FAIL st_hold_cycles got %0d exp 5", hold_cnt); else n_pass++;
    n_checks++; if (bad_hold !== 0) $display("FAIL st_hold_data got %0d bad exp 0", bad_hold); else n_pass++;
    n_checks++; if (stb_addr_h.size() !== 20) $display("FAIL st_stb_cycles got %0d exp 20", stb_addr_h.size()); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      n_checks++; if (acc_addr[k] !== 32'h100 + 32'(2*k) || acc_data[k] !== 16'hA000 + 16'(k))
        $display("FAIL st_word[%0d] got a=%h d=%h exp a=%h d=%h", k, acc_addr[k], acc_data[k],
                 32'h100 + 32'(2*k), 16'hA000 + 16'(k));
      else n_pass++;
    end
    n_checks++; if (rsp_cycle !== 22) $display("FAIL st_rsp_cycle got %0d exp 22", rsp_cycle); else n_pass++;
    tick(); wb_ack = 1'b0;
  endtask

  task automatic test_slow_ack();
    logic [255:0] exp;
    for (int k = 0; k < 16; k++) exp[k*16 +: 16] = 16'(32'h300 + 2*k);
    issue_req(1'b0, 32'h0000_0300, '0);
    run_slave(-1, 0, 2, 0, 1'b1, 64);
    n_checks++; if (last_ack !== 32) $display("FAIL sa_last_ack got %0d exp 32", last_ack); else n_pass++;
    n_checks++; if (cyc_hist[32] !== 1'b1 || cyc_hist[33] !== 1'b0)
      $display("FAIL sa_cyc_drop got c32=%b c33=%b exp 1 0", cyc_hist[32], cyc_hist[33]); else n_pass++;
    n_checks++; if (rsp_cycle !== 33) $display("FAIL sa_rsp_cycle got %0d exp 33", rsp_cycle); else n_pass++;
    tick(); wb_ack = 1'b0;
    n_checks++; if (rsp_data !== exp) $display("FAIL sa_line got %h exp %h", rsp_data, exp); else n_pass++;
    wb_ack = 1'b1; wb_rdata = 16'hBEEF;
    tick(); wb_ack = 1'b0;
    n_checks++; if (rsp_data !== exp || rsp_valid !== 1'b0 || wb_cyc !== 1'b0)
      $display("FAIL sa_idle_ack got v=%b cyc=%b d=%h exp 0 0 %h", rsp_valid, wb_cyc, rsp_data, exp); else n_pass++;
  endtask

  task automatic test_reset_midburst();
    logic [255:0] exp;
    int pulses = 0;
    issue_req(1'b0, 32'h0000_0400, '0);
    run_slave(-1, 0, 1, 5, 1'b0, 64);
    rst = 1'b1;
    tick();
    n_checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0)
      $display("FAIL mr_cyc_stb got cyc=%b stb=%b exp 0 0", wb_cyc, wb_stb); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL mr_state got v=%b rdy=%b exp 0 1", rsp_valid, req_ready); else n_pass++;
    n_checks++; if (rsp_data !== 256'h0) $display("FAIL mr_data got %h exp 0", rsp_data); else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) pulses++;
      tick();
    end
    n_checks++; if (pulses !== 0) $display("FAIL mr_no_rsp got %0d exp 0", pulses); else n_pass++;
    for (int k = 0; k < 16; k++) exp[k*16 +: 16] = 16'(32'h200 + 2*k);
    issue_req(1'b0, 32'h0000_0200, '0);
    run_slave(-1, 0, 1, 0, 1'b0, 64);
    n_checks++; if (rsp_cycle !== 18) $display("FAIL mr_rd_cycle got %0d exp 18", rsp_cycle); else n_pass++;
    n_checks++; if (rsp_data !== exp) $display("FAIL mr_rd_line got %h exp %h", rsp_data, exp); else n_pass++;
    tick(); wb_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    req_we = 1'b0; req_addr = 32'h0000_0500; req_data = '0; req_valid = 1'b1;
    tick();
    run_slave(-1, 0, 1, 0, 1'b0, 64);
    n_checks++; if (rsp_cycle !== 18 || ready_seen !== 0)
      $display("FAIL bb_first got rsp=%0d rdy=%0d exp 18 0", rsp_cycle, ready_seen); else n_pass++;
    n_checks++; if (stb_addr_h.size() !== 16) $display("FAIL bb_first_stb got %0d exp 16", stb_addr_h.size()); else n_pass++;
    tick(); wb_ack = 1'b0;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL bb_idle_ready got %b exp 1", req_ready); else n_pass++;
    tick();
    req_valid = 1'b0;
    n_checks++; if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || wb_addr !== 32'h500 || req_ready !== 1'b0)
      $display("FAIL bb_second got cyc=%b stb=%b a=%h rdy=%b exp 1 1 500 0", wb_cyc, wb_stb, wb_addr, req_ready);
    else n_pass++;
    run_slave(-1, 0, 1, 0, 1'b0, 64);
    n_checks++; if (rsp_cycle !== 18 || ready_seen !== 0)
      $display("FAIL bb_second_rsp got rsp=%0d rdy=%0d exp 18 0", rsp_cycle, ready_seen); else n_pass++;
    tick(); wb_ack = 1'b0;
    n_checks++; if (req_ready !== 1'b1 || wb_cyc !== 1'b0)
      $display("FAIL bb_end got rdy=%b cyc=%b exp 1 0", req_ready, wb_cyc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write();
    test_stall();
    test_slow_ack();
    test_reset_midburst();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
